// File: rtl/data_path_pkg.sv
// Shared constants for the single-bus datapath: register width and bus-source
// indices. Enum order is the bus priority order, with the lowest index winning.
package data_path_pkg;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 24;
    localparam int SEL_W   = 5;

    typedef enum logic [SEL_W-1:0] {
        SRC_R0     = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
        SRC_R4     = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
        SRC_R8     = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
        SRC_R12    = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
        SRC_HI     = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19,
        SRC_PC     = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_Y = 5'd23
    } bus_src_e;

endpackage

// File: rtl/data_path_reg32.sv
// WIDTH-bit register with load enable and asynchronous active-high clear.
module data_path_reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: 24 registers share BusMuxOut through a priority
// encoder and mux. Zhigh/Zlow load from the external ALU, MDR from memory or the bus.
module data_path
    import data_path_pkg::*;
#(
    parameter int WIDTH = data_path_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             Read,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] RegisterAImmediate,
    input  logic [WIDTH-1:0] MDataIn,
    input  logic             R0out,  R1out,  R2out,  R3out,
    input  logic             R4out,  R5out,  R6out,  R7out,
    input  logic             R8out,  R9out,  R10out, R11out,
    input  logic             R12out, R13out, R14out, R15out,
    input  logic             HIout,  LOout,  Zhighout, Zlowout,
    input  logic             PCout,  MDRout, InPortout, Yout,
    input  logic             R0in,   R1in,   R2in,   R3in,
    input  logic             R4in,   R5in,   R6in,   R7in,
    input  logic             R8in,   R9in,   R10in,  R11in,
    input  logic             R12in,  R13in,  R14in,  R15in,
    input  logic             HIin,   LOin,   Zhighin, Zlowin,
    input  logic             PCin,   MDRin,  InPortin, Yin,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] mdrdata,
    output logic [WIDTH-1:0] BusMuxInR0,
    output logic [WIDTH-1:0] BusMuxInR1,
    output logic [WIDTH-1:0] BusMuxInR2
);

    logic [NUM_SRC-1:0]            out_vec;
    logic [NUM_SRC-1:0]            in_vec;
    logic [NUM_SRC-1:0][WIDTH-1:0] reg_q;
    logic [NUM_SRC-1:0][WIDTH-1:0] reg_d;
    logic [SEL_W-1:0]              bus_sel;
    logic                          bus_hit;

    // Bit position in these vectors equals the bus_src_e index.
    assign out_vec = {Yout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                      R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign in_vec  = {Yin, InPortin, MDRin, PCin, Zlowin, Zhighin, LOin, HIin,
                      R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    // Scan from lowest priority upward so the lowest asserted index wins.
    always_comb begin
        bus_sel = '0;
        bus_hit = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (out_vec[i]) begin
                bus_sel = SEL_W'(i);
                bus_hit = 1'b1;
            end
        end
    end

    assign BusMuxOut = bus_hit ? reg_q[bus_sel] : '0;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) reg_d[i] = BusMuxOut;
        reg_d[SRC_ZHI] = RegisterAImmediate;
        reg_d[SRC_ZLO] = A;
        reg_d[SRC_MDR] = Read ? MDataIn : BusMuxOut;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_reg
        data_path_reg32 #(.WIDTH(WIDTH)) u_reg (
            .clock (clock),
            .clear (clear),
            .en    (in_vec[i]),
            .d     (reg_d[i]),
            .q     (reg_q[i])
        );
    end

    assign mdrdata    = reg_q[SRC_MDR];
    assign BusMuxInR0 = reg_q[SRC_R0];
    assign BusMuxInR1 = reg_q[SRC_R1];
    assign BusMuxInR2 = reg_q[SRC_R2];

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus randomized
// traffic against an array-based register model.
module tb_data_path;

    localparam int HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, INP = 22, Y = 23;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        Read  = 1'b0;
    logic [31:0] a_in = '0, imm_in = '0, mdata_in = '0;
    logic [23:0] out_v = '0, in_v = '0;
    logic [31:0] bus, mdrdata, tap0, tap1, tap2;

    logic [31:0] m [24];
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear), .Read(Read),
        .A(a_in), .RegisterAImmediate(imm_in), .MDataIn(mdata_in),
        .R0out(out_v[0]),   .R1out(out_v[1]),   .R2out(out_v[2]),   .R3out(out_v[3]),
        .R4out(out_v[4]),   .R5out(out_v[5]),   .R6out(out_v[6]),   .R7out(out_v[7]),
        .R8out(out_v[8]),   .R9out(out_v[9]),   .R10out(out_v[10]), .R11out(out_v[11]),
        .R12out(out_v[12]), .R13out(out_v[13]), .R14out(out_v[14]), .R15out(out_v[15]),
        .HIout(out_v[16]),  .LOout(out_v[17]),  .Zhighout(out_v[18]), .Zlowout(out_v[19]),
        .PCout(out_v[20]),  .MDRout(out_v[21]), .InPortout(out_v[22]), .Yout(out_v[23]),
        .R0in(in_v[0]),     .R1in(in_v[1]),     .R2in(in_v[2]),     .R3in(in_v[3]),
        .R4in(in_v[4]),     .R5in(in_v[5]),     .R6in(in_v[6]),     .R7in(in_v[7]),
        .R8in(in_v[8]),     .R9in(in_v[9]),     .R10in(in_v[10]),   .R11in(in_v[11]),
        .R12in(in_v[12]),   .R13in(in_v[13]),   .R14in(in_v[14]),   .R15in(in_v[15]),
        .HIin(in_v[16]),    .LOin(in_v[17]),    .Zhighin(in_v[18]), .Zlowin(in_v[19]),
        .PCin(in_v[20]),    .MDRin(in_v[21]),   .InPortin(in_v[22]), .Yin(in_v[23]),
        .BusMuxOut(bus), .mdrdata(mdrdata),
        .BusMuxInR0(tap0), .BusMuxInR1(tap1), .BusMuxInR2(tap2)
    );

    // Reference bus: first asserted source in priority order, else zero.
    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 24; i++) if (out_v[i]) return m[i];
        return 32'h0;
    endfunction

    // Advance one clock edge, updating the model from the current strobes.
    task automatic tick();
        logic [31:0] nxt [24];
        logic [31:0] b;
        b = model_bus();
        for (int i = 0; i < 24; i++) begin
            nxt[i] = m[i];
            if (in_v[i]) begin
                if (i == ZHI)      nxt[i] = imm_in;
                else if (i == ZLO) nxt[i] = a_in;
                else if (i == MDR) nxt[i] = Read ? mdata_in : b;
                else               nxt[i] = b;
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 24; i++) m[i] = nxt[i];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 24; i++) m[i] = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear = 1'b1; model_clear();
        #2;
        checks++; if (bus !== 32'h0) begin failures++; $display("FAIL reset_bus got=%h exp=%h", bus, 32'h0); end
        checks++; if (mdrdata !== 32'h0) begin failures++; $display("FAIL reset_mdr got=%h exp=%h", mdrdata, 32'h0); end
        checks++; if ({tap0, tap1, tap2} !== 96'h0) begin failures++; $display("FAIL reset_taps got=%h exp=0", {tap0, tap1, tap2}); end
        @(negedge clock); clear = 1'b0;
        v = $urandom | 32'h1;
        mdata_in = v; Read = 1'b1; in_v = 24'h0; in_v[MDR] = 1'b1; tick();
        Read = 1'b0; out_v = 24'h0; out_v[MDR] = 1'b1; in_v = 24'h0; in_v[1] = 1'b1; tick();
        out_v = '0; in_v = '0;
        checks++; if (tap1 !== v) begin failures++; $display("FAIL pre_clear_r1 got=%h exp=%h", tap1, v); end
        // Clear mid-cycle; everything must be zero before the next edge.
        @(posedge clock); #3; clear = 1'b1; model_clear(); #1;
        checks++; if (tap1 !== 32'h0) begin failures++; $display("FAIL async_clear_r1 got=%h exp=0", tap1); end
        checks++; if (mdrdata !== 32'h0) begin failures++; $display("FAIL async_clear_mdr got=%h exp=0", mdrdata); end
        out_v[1] = 1'b1; #1;
        checks++; if (bus !== 32'h0) begin failures++; $display("FAIL async_clear_bus got=%h exp=0", bus); end
        out_v = '0;
        // Clear held through an edge with every load strobe high.
        mdata_in = 32'hDEAD_BEEF; Read = 1'b1; in_v = 24'hFF_FFFF;
        @(posedge clock); #1;
        checks++; if (mdrdata !== 32'h0) begin failures++; $display("FAIL clear_dominates_mdr got=%h exp=0", mdrdata); end
        in_v = '0; Read = 1'b0;
        @(negedge clock); clear = 1'b0;
    endtask

    task automatic test_mdr_load();
        logic [31:0] vals [3] = '{32'h12, 32'h14, 32'h18};
        int          dst  [3] = '{2, 3, 1};
        for (int k = 0; k < 3; k++) begin
            mdata_in = vals[k]; Read = 1'b1; out_v = '0; in_v = '0; in_v[MDR] = 1'b1; tick();
            checks++; if (mdrdata !== vals[k]) begin failures++; $display("FAIL mdr_load%0d got=%h exp=%h", k, mdrdata, vals[k]); end
            Read = 1'b0; out_v[MDR] = 1'b1; in_v = '0; in_v[dst[k]] = 1'b1; tick();
            out_v = '0; in_v = '0;
        end
        checks++; if (tap2 !== 32'h12) begin failures++; $display("FAIL mdr_to_r2 got=%h exp=%h", tap2, 32'h12); end
        repeat (3) tick();
        checks++; if (tap0 !== 32'h0) begin failures++; $display("FAIL hold_r0 got=%h exp=0", tap0); end
        checks++; if (tap1 !== 32'h18) begin failures++; $display("FAIL hold_r1 got=%h exp=%h", tap1, 32'h18); end
        checks++; if (tap2 !== 32'h12) begin failures++; $display("FAIL hold_r2 got=%h exp=%h", tap2, 32'h12); end
        out_v[3] = 1'b1; #1;
        checks++; if (bus !== 32'h14) begin failures++; $display("FAIL hold_r3 got=%h exp=%h", bus, 32'h14); end
        out_v = '0;
    endtask

    task automatic test_bus_move();
        out_v = '0; out_v[2] = 1'b1; in_v = '0; in_v[Y] = 1'b1; tick();
        in_v = '0; out_v = '0; out_v[Y] = 1'b1; #1;
        checks++; if (bus !== 32'h12) begin failures++; $display("FAIL move_r2_y got=%h exp=%h", bus, 32'h12); end
        Read = 1'b0; out_v = '0; out_v[3] = 1'b1; in_v[MDR] = 1'b1; tick();
        checks++; if (mdrdata !== 32'h14) begin failures++; $display("FAIL mdr_from_bus got=%h exp=%h", mdrdata, 32'h14); end
        out_v = '0; out_v[2] = 1'b1; in_v = '0; in_v[2] = 1'b1; tick();
        checks++; if (tap2 !== 32'h12) begin failures++; $display("FAIL self_move_r2 got=%h exp=%h", tap2, 32'h12); end
        mdata_in = 32'hCAFE_0001; Read = 1'b1; out_v = '0; in_v = '0; tick();
        checks++; if (mdrdata !== 32'h14) begin failures++; $display("FAIL read_alone got=%h exp=%h", mdrdata, 32'h14); end
        Read = 1'b0;
    endtask

    task automatic test_z_path();
        a_in = 32'h2891_8000; imm_in = 32'h1; out_v = '0; in_v = '0;
        in_v[ZLO] = 1'b1; in_v[ZHI] = 1'b1; tick();
        in_v = '0; out_v[ZLO] = 1'b1; #1;
        checks++; if (bus !== 32'h2891_8000) begin failures++; $display("FAIL zlow got=%h exp=%h", bus, 32'h2891_8000); end
        out_v = '0; out_v[ZHI] = 1'b1; #1;
        checks++; if (bus !== 32'h1) begin failures++; $display("FAIL zhigh got=%h exp=%h", bus, 32'h1); end
        out_v = '0;
    endtask

    task automatic test_priority();
        out_v = '0; out_v[1] = 1'b1; out_v[3] = 1'b1; #1;
        checks++; if (bus !== 32'h18) begin failures++; $display("FAIL prio_r1_r3 got=%h exp=%h", bus, 32'h18); end
        out_v = '0; out_v[ZLO] = 1'b1; out_v[Y] = 1'b1; #1;
        checks++; if (bus !== 32'h2891_8000) begin failures++; $display("FAIL prio_zlo_y got=%h exp=%h", bus, 32'h2891_8000); end
        out_v = '0; #1;
        checks++; if (bus !== 32'h0) begin failures++; $display("FAIL idle_bus got=%h exp=0", bus); end
    endtask

    task automatic test_random();
        logic [31:0] exp_b;
        for (int n = 0; n < 300; n++) begin
            out_v = '0;
            if ($urandom_range(0, 3) != 0) out_v[$urandom_range(0, 23)] = 1'b1;
            if ($urandom_range(0, 3) == 0) out_v[$urandom_range(0, 23)] = 1'b1;
            in_v     = 24'($urandom & $urandom);
            Read     = 1'($urandom);
            a_in     = $urandom;
            imm_in   = $urandom;
            mdata_in = $urandom;
            #1;
            exp_b = model_bus();
            checks++; if (bus !== exp_b) begin failures++; $display("FAIL rand_bus%0d got=%h exp=%h", n, bus, exp_b); end
            tick();
            checks++; if (mdrdata !== m[MDR]) begin failures++; $display("FAIL rand_mdr%0d got=%h exp=%h", n, mdrdata, m[MDR]); end
            checks++; if ({tap0, tap1, tap2} !== {m[0], m[1], m[2]}) begin
                failures++; $display("FAIL rand_taps%0d got=%h exp=%h", n, {tap0, tap1, tap2}, {m[0], m[1], m[2]});
            end
        end
        in_v = '0;
        for (int i = 0; i < 24; i++) begin
            out_v = '0; out_v[i] = 1'b1; #1;
            checks++; if (bus !== m[i]) begin failures++; $display("FAIL readback_src%0d got=%h exp=%h", i, bus, m[i]); end
        end
        out_v = '0;
    endtask

    initial begin
        model_clear();
        @(negedge clock);
        test_reset();
        test_mdr_load();
        test_bus_move();
        test_z_path();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
